// File: rtl/instr_decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_pkg
// Shared RV32I decode definitions. This package holds:
//   - the major opcode constants
//   - the immediate-format enum
//   - the skid-buffer state enum
//   - the decoded-entry struct carried through the decode stage
//   - a helper that flags the reserved conditional-branch funct3 encodings
// ---------------------------------------------------------------------------
package instr_decode_stage_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] target;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } decoded_t;

  // funct3 values 010 and 011 are unassigned in the conditional-branch group.
  function automatic logic is_bad_branch_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b010) || (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_imm_gen
// Combinational immediate generator. It classifies the instruction by opcode
// into an immediate format and produces the sign-extended immediate.
// Ports:
//   instr  in   32  raw instruction word
//   imm    out  32  sign-extended immediate (0 when the format is unknown)
//   fmt    out   3  immediate format (FMT_NONE for unsupported opcodes)
// ---------------------------------------------------------------------------
module instr_decode_stage_imm_gen
  import instr_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_fmt_e    fmt
);

  // Scatter/gather the immediate bits for each format. Anything that is not
  // one of the immediate-carrying opcodes leaves fmt at FMT_NONE, and the
  // top marks such words illegal.
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      // Register-register ops carry no immediate and fall into the
      // unsupported-format bucket with everything else.
      OP_REG:  fmt = FMT_NONE;
      default: fmt = FMT_NONE;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
// Registered RV32I decode stage between the fetch and execute stages. Words
// are decoded on the input side and captured into a main/skid register pair.
// The stage uses valid/ready handshakes on both sides.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   flush                      drop every buffered entry (branch redirect)
//   in_valid/in_ready          fetch handshake (in_ready is registered)
//   in_instr, in_pc            raw word and its address
//   out_valid/out_ready        execute handshake
//   out_pc                     entry PC (RESET_PC while empty)
//   out_opcode/rd/rs1/rs2      raw instruction fields
//   out_funct3/out_funct7      raw instruction fields
//   out_imm                    sign-extended immediate
//   out_target                 pc + imm for branch/JAL, else 0
//   out_is_branch/jal/jalr     control-flow class (legal words only)
//   out_illegal                unsupported opcode or reserved branch funct3
// ---------------------------------------------------------------------------
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic            out_is_branch,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_illegal
);

  state_e      state_q, state_d;
  decoded_t    dec, main_q, skid_q, shown;
  logic [31:0] imm;
  imm_fmt_e    fmt;
  logic        in_ready_q;
  logic        accept, pop;
  logic        load_main, main_from_skid, load_skid;
  logic        bad_branch;

  instr_decode_stage_imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm),
    .fmt   (fmt)
  );

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;

  // Decode the incoming word before capture. Execute then sees
  // register-clean fields and nothing is recomputed on the output side.
  always_comb begin
    dec        = '0;
    bad_branch = (fmt == FMT_B) && is_bad_branch_funct3(in_instr[14:12]);
    dec.pc        = in_pc;
    dec.opcode    = in_instr[6:0];
    dec.rd        = in_instr[11:7];
    dec.funct3    = in_instr[14:12];
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.funct7    = in_instr[31:25];
    dec.imm       = imm;
    dec.illegal   = (fmt == FMT_NONE) || bad_branch;
    dec.is_branch = (fmt == FMT_B) && !bad_branch;
    dec.is_jal    = (fmt == FMT_J);
    dec.is_jalr   = (in_instr[6:0] == OP_JALR);
    if (dec.is_branch || dec.is_jal) begin
      dec.target = in_pc + imm;
    end
  end

  // Next-state logic for the two-entry buffer. Main always holds the oldest
  // entry. The skid register only fills when a word arrives while main is
  // stalled. Flush overrides everything and drops the word offered that cycle.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and data registers. in_ready is registered from the next state, so
  // out_ready never reaches in_ready through combinational logic.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : dec;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  // Outputs read as zero while empty, so a stale entry left in main after a
  // pop or flush is never visible. The PC idles at RESET_PC.
  assign shown         = out_valid ? main_q : '0;
  assign out_pc        = out_valid ? main_q.pc : RESET_PC;
  assign out_opcode    = shown.opcode;
  assign out_rd        = shown.rd;
  assign out_rs1       = shown.rs1;
  assign out_rs2       = shown.rs2;
  assign out_funct3    = shown.funct3;
  assign out_funct7    = shown.funct7;
  assign out_imm       = shown.imm;
  assign out_target    = shown.target;
  assign out_is_branch = shown.is_branch;
  assign out_is_jal    = shown.is_jal;
  assign out_is_jalr   = shown.is_jalr;
  assign out_illegal   = shown.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
// Scoreboard bench for instr_decode_stage. Each driven word pushes its
// expected decoded output. A negedge monitor pops and compares every entry
// that execute consumes, and also checks that outputs hold while stalled.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0400;
  localparam logic [131:0] RESET_VEC = {RST_PC, 100'd0};

  logic        Clk = 1'b0;
  logic        Reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm, out_target;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_is_branch, out_is_jal, out_is_jalr, out_illegal;

  typedef struct packed {
    logic [131:0] vec;
    logic [131:0] mask;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [131:0] obs;
  logic [131:0] prev_obs;
  logic         prev_hold = 1'b0;
  logic [131:0] full_mask;
  logic [131:0] no_tgt_mask;

  always #5 Clk = ~Clk;

  instr_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_target(out_target), .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
    .out_is_jalr(out_is_jalr), .out_illegal(out_illegal)
  );

  assign obs = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                out_imm, out_target, out_is_branch, out_is_jal, out_is_jalr, out_illegal};

  // Expected entry: raw fields come straight from the word, while the
  // immediate, target and flags are hand-derived constants from each test.
  function automatic logic [131:0] pack_exp(input logic [31:0] instr, input logic [31:0] pc,
                                            input logic [31:0] imm, input logic [31:0] target,
                                            input logic br, input logic jal,
                                            input logic jalr, input logic ill);
    return {pc, instr[6:0], instr[11:7], instr[19:15], instr[24:20], instr[14:12],
            instr[31:25], imm, target, br, jal, jalr, ill};
  endfunction

  // Consume monitor: compare each popped entry with the scoreboard head, and
  // check that outputs held steady across every stalled edge.
  always @(negedge Clk) begin
    if (prev_hold) begin
      n_cmp++;
      if (obs !== prev_obs) begin
        n_bad++;
        $display("[TB] FAIL hold_stable: got %h, required %h", obs, prev_obs);
      end
    end
    prev_hold = out_valid && !out_ready && !flush && !Reset;
    prev_obs  = obs;
    if (!Reset && !flush && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_output: got %h, required no entry", obs);
      end else begin
        mon_e = sb.pop_front();
        if ((obs & mon_e.mask) !== (mon_e.vec & mon_e.mask)) begin
          n_bad++;
          $display("[TB] FAIL decode_entry: got %h, required %h", obs & mon_e.mask,
                   mon_e.vec & mon_e.mask);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic keep,
                      input logic [131:0] vec, input logic [131:0] mask);
    int   guard;
    exp_t e;
    guard    = 0;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL send_accept: in_ready=%b, required 1", in_ready);
    end else if (keep) begin
      e.vec  = vec;
      e.mask = mask;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 30) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h0062_8663; in_pc = 32'd28;
    tick();
    tick();
    Reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_valid: got %b, required 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL reset_ready: got %b, required 1", in_ready);
    end
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++; $display("[TB] FAIL reset_outputs: got %h, required %h", obs, RESET_VEC);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL reset_no_capture: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    send(32'h0062_8663, 32'd28, 1'b1,
         pack_exp(32'h0062_8663, 32'd28, 32'h0000_000C, 32'h0000_0028, 1, 0, 0, 0), full_mask);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("[TB] FAIL latency_valid: got %b, required 1", out_valid);
    end
    send(32'hFE62_8AE3, 32'd28, 1'b1,
         pack_exp(32'hFE62_8AE3, 32'd28, 32'hFFFF_FFF4, 32'h0000_0010, 1, 0, 0, 0), full_mask);
    wait_drain();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL empty_after_pop: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(32'h1234_52B7, 32'h200, 1'b1,
         pack_exp(32'h1234_52B7, 32'h200, 32'h1234_5000, 32'h0, 0, 0, 0, 0), full_mask);
    send(32'hFFF2_8293, 32'h204, 1'b1,
         pack_exp(32'hFFF2_8293, 32'h204, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0), full_mask);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL full_ready: got %b, required 0", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("[TB] FAIL full_valid: got %b, required 1", out_valid);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("[TB] FAIL stall_ready: got %b, required 0", in_ready);
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_jal();
    out_ready = 1'b1;
    send(32'h0080_00EF, 32'h100, 1'b1,
         pack_exp(32'h0080_00EF, 32'h100, 32'h8, 32'h108, 0, 1, 0, 0), full_mask);
    send(32'h0080_00EF, 32'hFFFF_FFFC, 1'b1,
         pack_exp(32'h0080_00EF, 32'hFFFF_FFFC, 32'h8, 32'h4, 0, 1, 0, 0), full_mask);
    wait_drain();
  endtask

  task automatic test_formats();
    out_ready = 1'b1;
    send(32'h0000_0000, 32'h300, 1'b1,
         pack_exp(32'h0000_0000, 32'h300, 32'h0, 32'h0, 0, 0, 0, 1), full_mask);
    send(32'h0062_A423, 32'h304, 1'b1,
         pack_exp(32'h0062_A423, 32'h304, 32'h8, 32'h0, 0, 0, 0, 0), full_mask);
    send(32'hFE62_AE23, 32'h308, 1'b1,
         pack_exp(32'hFE62_AE23, 32'h308, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0), full_mask);
    send(32'hFF80_8067, 32'h30C, 1'b1,
         pack_exp(32'hFF80_8067, 32'h30C, 32'hFFFF_FFF8, 32'h0, 0, 0, 1, 0), full_mask);
    send(32'h0000_1517, 32'h310, 1'b1,
         pack_exp(32'h0000_1517, 32'h310, 32'h0000_1000, 32'h0, 0, 0, 0, 0), full_mask);
    send(32'hFFC2_A303, 32'h314, 1'b1,
         pack_exp(32'hFFC2_A303, 32'h314, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0), full_mask);
    send(32'h0062_9663, 32'h318, 1'b1,
         pack_exp(32'h0062_9663, 32'h318, 32'hC, 32'h324, 1, 0, 0, 0), full_mask);
    send(32'h0062_A663, 32'h31C, 1'b1,
         pack_exp(32'h0062_A663, 32'h31C, 32'hC, 32'h0, 0, 0, 0, 1), no_tgt_mask);
    wait_drain();
  endtask

  task automatic test_flush();
    // Flush while holding one entry, with a word accepted in the same cycle.
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h500, 1'b0, '0, '0);
    in_instr = 32'h0010_0093; in_pc = 32'h504; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_one_valid: got %b, required 0", out_valid);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_one_dropped: got %b, required 0", out_valid);
    end
    // Flush from FULL with a new word offered.
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h600, 1'b0, '0, '0);
    send(32'h0010_0093, 32'h604, 1'b0, '0, '0);
    in_instr = 32'h0020_0113; in_pc = 32'h608; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_full_valid: got %b, required 0", out_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("[TB] FAIL flush_full_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_full_dropped: got %b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    send(32'h0000_0013, 32'h700, 1'b0, '0, '0);
    send(32'h0010_0093, 32'h704, 1'b0, '0, '0);
    in_instr = 32'h0020_0113; in_pc = 32'h708; in_valid = 1'b1; flush = 1'b1; Reset = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; Reset = 1'b0;
    n_cmp++;
    if (obs !== RESET_VEC) begin
      n_bad++; $display("[TB] FAIL reset_flush_outputs: got %h, required %h", obs, RESET_VEC);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_flush_hs: valid=%b ready=%b, required valid=0 ready=1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    send(32'h0062_8663, 32'h40, 1'b1,
         pack_exp(32'h0062_8663, 32'h40, 32'hC, 32'h4C, 1, 0, 0, 0), full_mask);
    wait_drain();
  endtask

  initial begin
    full_mask   = '1;
    no_tgt_mask = '1;
    no_tgt_mask[35:4] = '0;
    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_branch();
    test_back_to_back();
    test_jal();
    test_formats();
    test_flush();
    test_reset_flush();
    repeat (3) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("[TB] FAIL final_queue: %0d left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
